// File: rtl/bus_arb_mux.sv
// Purpose: NCH-to-1 channel mux/arbiter (MODE 0 direct select, MODE 1 round-robin) with a registered output stage.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle sustained while out_ready is high.
// Backpressure: out_valid && !out_ready holds the output word and drops every in_ready bit.
// Optional: define BUS_ARB_MUX_SEL_ERR_EN to add the sticky sel_err output.
module bus_arb_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int MODE  = 0,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef BUS_ARB_MUX_SEL_ERR_EN
    ,
    output logic                  sel_err
`endif
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  gnt;
    logic             gnt_vld;
    logic             sel_bad;
    logic             ld;
    logic [WIDTH-1:0] gnt_dat;
    logic [SELW-1:0]  idx;

    assign ld = !out_valid || out_ready;

    // Grant selection: direct select in MODE 0, round-robin starting after ptr in MODE 1.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        sel_bad = 1'b0;
        idx     = '0;
        if (MODE == 0) begin
            if (int'(sel) < NCH) begin
                gnt     = sel;
                gnt_vld = in_valid[sel];
            end else begin
                sel_bad = 1'b1;
            end
        end else begin
            // Walk the candidates from farthest to nearest so the nearest valid one wins.
            for (int k = NCH; k >= 1; k--) begin
                idx = SELW'((int'(ptr) + k) % NCH);
                if (in_valid[idx]) begin
                    gnt     = idx;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    // Data word of the granted channel.
    always_comb begin
        gnt_dat = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SELW'(i) == gnt) begin
                gnt_dat = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready for the granted channel, forced low while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (ld && gnt_vld && !rst) begin
            in_ready[gnt] = 1'b1;
        end
    end

    // Output register and round-robin pointer; ptr only moves on an accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(NCH - 1);
        end else if (ld) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data <= gnt_dat;
                out_ch   <= gnt;
                ptr      <= gnt;
            end
        end
    end

`ifdef BUS_ARB_MUX_SEL_ERR_EN
    // Sticky flag for an out-of-range select seen while the output stage could load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (sel_bad && ld) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench: MODE 0 (NCH=3) and MODE 1 (NCH=4) instances side by side.
// Outputs are sampled 1 ns after the rising edge; inputs change right after sampling.
module tb_bus_arb_mux;

    logic        clk;
    logic        rst;

    logic [23:0] d0;
    logic [2:0]  v0;
    logic [2:0]  r0;
    logic [1:0]  sel0;
    logic [7:0]  od0;
    logic [1:0]  oc0;
    logic        ov0;
    logic        ordy0;
`ifdef BUS_ARB_MUX_SEL_ERR_EN
    logic        se0;
    logic        se1;
`endif

    logic [31:0] d1;
    logic [3:0]  v1;
    logic [3:0]  r1;
    logic [1:0]  sel1;
    logic [7:0]  od1;
    logic [1:0]  oc1;
    logic        ov1;
    logic        ordy1;

    int total = 0;
    int bad   = 0;

    bus_arb_mux #(.WIDTH(8), .NCH(3), .MODE(0)) u0 (
        .clk(clk), .rst(rst),
        .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(sel0),
        .out_data(od0), .out_ch(oc0), .out_valid(ov0), .out_ready(ordy0)
`ifdef BUS_ARB_MUX_SEL_ERR_EN
        , .sel_err(se0)
`endif
    );

    bus_arb_mux #(.WIDTH(8), .NCH(4), .MODE(1)) u1 (
        .clk(clk), .rst(rst),
        .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(sel1),
        .out_data(od1), .out_ch(oc1), .out_valid(ov1), .out_ready(ordy1)
`ifdef BUS_ARB_MUX_SEL_ERR_EN
        , .sel_err(se1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        d0    = 24'h33_22_11;
        v0    = 3'b111;
        sel0  = 2'd0;
        ordy0 = 1'b1;
        d1    = 32'h44_33_22_11;
        v1    = 4'b1111;
        sel1  = 2'd0;
        ordy1 = 1'b1;

        // Reset state, with every channel valid
        #12;
        chk("rst_ov0", ov0, 0);
        chk("rst_od0", od0, 0);
        chk("rst_oc0", oc0, 0);
        chk("rst_r0",  r0,  0);
        chk("rst_ov1", ov1, 0);
        chk("rst_r1",  r1,  0);
`ifdef BUS_ARB_MUX_SEL_ERR_EN
        chk("rst_se0", se0, 0);
`endif
        v1  = 4'b0000;
        rst = 1'b0;
        #1;

        // MODE 0 direct select: SEL 0,1,2 on consecutive cycles
        chk("m0_r_sel0", r0, 3'b001);
        step();
        chk("m0_od_c1", od0, 8'h11);
        chk("m0_oc_c1", oc0, 0);
        chk("m0_ov_c1", ov0, 1);
        sel0 = 2'd1;
        #1 chk("m0_r_sel1", r0, 3'b010);
        step();
        chk("m0_od_c2", od0, 8'h22);
        chk("m0_oc_c2", oc0, 1);
        sel0 = 2'd2;
        step();
        chk("m0_od_c3", od0, 8'h33);
        chk("m0_oc_c3", oc0, 2);

        // MODE 0 out-of-range select
        sel0 = 2'd3;
        #1 chk("m0_r_sel3", r0, 3'b000);
        step();
        chk("m0_ov_sel3", ov0, 0);
        chk("m0_od_hold", od0, 8'h33);
        chk("m0_oc_hold", oc0, 2);
`ifdef BUS_ARB_MUX_SEL_ERR_EN
        chk("m0_se_set", se0, 1);
`endif
        sel0 = 2'd0;
        step();
        chk("m0_ov_back", ov0, 1);
        chk("m0_od_back", od0, 8'h11);
`ifdef BUS_ARB_MUX_SEL_ERR_EN
        chk("m0_se_sticky", se0, 1);
`endif

        // MODE 1 round-robin, all valid: 0,1,2,3,0
        v1 = 4'b1111;
        #1 chk("m1_r_first", r1, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("m1_oc_%0d", i), oc1, i % 4);
            chk($sformatf("m1_od_%0d", i), od1, 8'h11 * ((i % 4) + 1));
        end
        step();
        chk("m1_oc_5", oc1, 1);
        chk("m1_od_5", od1, 8'h22);

        // Backpressure: hold 8'h22 for 3 cycles while inputs churn
        ordy1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d1   = 32'hA5A5_5A5A ^ (32'h0101_0101 * i);
            sel1 = 2'(i + 1);
            #1 chk($sformatf("bp_r_%0d", i), r1, 0);
            step();
            chk($sformatf("bp_od_%0d", i), od1, 8'h22);
            chk($sformatf("bp_oc_%0d", i), oc1, 1);
            chk($sformatf("bp_ov_%0d", i), ov1, 1);
        end
        d1    = 32'h44_33_22_11;
        ordy1 = 1'b1;
        #1 chk("bp_ptr_r", r1, 4'b0100);
        step();
        chk("bp_ptr_oc", oc1, 2);
        chk("bp_ptr_od", od1, 8'h33);

        // Sparse valid with wrap: ptr=2, channels 0 and 3 valid -> 3 then 0
        v1 = 4'b1001;
        #1 chk("sp_r_a", r1, 4'b1000);
        step();
        chk("sp_oc_a", oc1, 3);
        chk("sp_od_a", od1, 8'h44);
        chk("sp_r_b", r1, 4'b0001);
        step();
        chk("sp_oc_b", oc1, 0);
        chk("sp_od_b", od1, 8'h11);

        // No grant: valid drops, data/channel hold
        v1 = 4'b0000;
        step();
        chk("ng_ov", ov1, 0);
        chk("ng_od", od1, 8'h11);
        chk("ng_oc", oc1, 0);

        // Reset pulsed between edges while a word is held
        v1 = 4'b1111;
        step();
        chk("mr_oc_pre", oc1, 1);
        chk("mr_ov_pre", ov1, 1);
        ordy1 = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mr_ov1", ov1, 0);
        chk("mr_od1", od1, 0);
        chk("mr_oc1", oc1, 0);
        chk("mr_r1",  r1,  0);
        chk("mr_ov0", ov0, 0);
        chk("mr_od0", od0, 0);
`ifdef BUS_ARB_MUX_SEL_ERR_EN
        chk("mr_se0", se0, 0);
`endif
        rst   = 1'b0;
        ordy1 = 1'b1;
        #1 chk("mr_r_first", r1, 4'b0001);
        step();
        chk("mr_oc_first", oc1, 0);
        chk("mr_od_first", od1, 8'h11);
        chk("mr_ov_first", ov1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The module SHALL have parameter NCH, default 4, range 2..16, giving the number of input channels.
REQ-003 The module SHALL have parameter MODE, default 0: 0 = direct select by SEL, 1 = round-robin arbitration with SEL ignored.
REQ-004 The module SHALL have local parameter SELW = clog2(NCH), giving the select and channel-tag width.
REQ-005 CLK  input  1  single clock; all state updates on the rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 IN_DATA  input  NCH*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 IN_VALID  input  NCH  per-channel valid.
REQ-009 IN_READY  output  NCH  per-channel ready; combinational.
REQ-010 SEL  input  SELW  channel select, used in MODE 0 only.
REQ-011 OUT_DATA  output  WIDTH  registered output word.
REQ-012 OUT_CH  output  SELW  registered index of the source channel of OUT_DATA.
REQ-013 OUT_VALID  output  1  registered output valid.
REQ-014 OUT_READY  input  1  downstream ready.

Function
REQ-015 Transfer rules SHALL be: an input transfer occurs when IN_VALID[i] && IN_READY[i]; an output transfer occurs when OUT_VALID && OUT_READY.
REQ-016 Load enable SHALL be LD = !OUT_VALID || OUT_READY.
REQ-017 At most one IN_READY bit SHALL be high per cycle, namely IN_READY[g] = LD && grant_valid, where g is the granted channel.
REQ-018 In MODE 0, the grant SHALL be g = SEL and grant_valid = IN_VALID[SEL]; if SEL >= NCH, there SHALL be no grant and all IN_READY bits SHALL be 0.
REQ-019 In MODE 1, g SHALL be the first channel with IN_VALID set, scanning upward with wrap from (PTR+1) mod NCH; grant_valid SHALL be 1 if any IN_VALID bit is set.
REQ-020 In MODE 1, PTR SHALL update to g only on an input transfer; it SHALL hold otherwise, including while OUT_READY is low.
REQ-021 On an input transfer, the next-cycle outputs SHALL be OUT_DATA = IN_DATA[g], OUT_CH = g, and OUT_VALID = 1.
REQ-022 When LD is high and there is no grant, OUT_VALID SHALL be 0 next cycle, and OUT_DATA and OUT_CH SHALL hold.
REQ-023 Latency SHALL be 1 cycle from input transfer to OUT_VALID.
REQ-024 Throughput SHALL be 1 word per cycle while OUT_READY is held high.
REQ-025 While OUT_VALID && !OUT_READY, OUT_DATA, OUT_CH and OUT_VALID SHALL be held stable and all IN_READY bits SHALL be 0.
REQ-026 In a simultaneous output transfer and input transfer, the new word SHALL replace the old with no bubble and no duplicate.
REQ-027 In MODE 1 wrap-around, with PTR = NCH-1 and all channels valid, the grant SHALL go to channel 0.
REQ-028 SEL changes while OUT_VALID is held SHALL NOT affect the held word.

Reset
REQ-029 While RST is high, the outputs SHALL be OUT_VALID = 0, OUT_DATA = 0 and OUT_CH = 0, and PTR SHALL be NCH-1, so that channel 0 has first priority.
REQ-030 While RST is high, all IN_READY bits SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard a held word immediately, without waiting for a clock edge.
REQ-032 The first grant after RST deasserts SHALL occur on the first rising edge of CLK.

Configuration
REQ-033 When macro BUS_ARB_MUX_SEL_ERR_EN is defined, the module SHALL add output SEL_ERR (1 bit, registered).
REQ-034 With the macro defined, SEL_ERR SHALL be set in the cycle after MODE 0 sees SEL >= NCH with LD high, and SHALL remain set until RST.
REQ-035 When the macro is undefined, SEL_ERR SHALL be absent and out-of-range SEL SHALL only suppress grants.

Verification
REQ-036 The bench SHALL check MODE 0, NCH=3: IN = 11/22/33 with all valid and OUT_READY=1; SEL 0,1,2 on consecutive cycles -> OUT_DATA 8'h11, 8'h22, 8'h33 on cycles 1-3 with OUT_CH 0,1,2.
REQ-037 The bench SHALL check MODE 0, NCH=3 with SEL=3 -> IN_READY=3'b000 and OUT_VALID falls next cycle; with the macro defined, SEL_ERR=1 and stays 1 until RST.
REQ-038 The bench SHALL check MODE 1, NCH=4, all valid, OUT_READY=1 -> OUT_CH sequence 0,1,2,3,0 on consecutive cycles.
REQ-039 The bench SHALL check backpressure: OUT_VALID=1 with OUT_DATA=8'h22 and OUT_READY=0 for 3 cycles, with IN_DATA and SEL changing -> OUT_DATA stays 8'h22, IN_READY=0, and PTR is unchanged.
REQ-040 The bench SHALL check reset mid-stream: RST pulsed between edges while OUT_VALID=1 -> OUT_VALID=0 and OUT_DATA=0 immediately; in MODE 1, the first grant after reset goes to channel 0.
